// File: rtl/pu_msp430_trace_arbiter.sv
// Dual-core MSP430 decode-trace arbiter: one event FIFO per core, drained round-robin
// into a registered valid/ready trace port.
module pu_msp430_trace_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        trc_en,
  input  logic        ovf_clr,
  input  logic        c0_decode,
  input  logic [15:0] c0_pc,
  input  logic [15:0] c0_ir,
  input  logic        c0_irq,
  input  logic        c1_decode,
  input  logic [15:0] c1_pc,
  input  logic [15:0] c1_ir,
  input  logic        c1_irq,
  output logic        trc_valid,
  input  logic        trc_ready,
  output logic        trc_core,
  output logic [15:0] trc_pc,
  output logic [15:0] trc_ir,
  output logic        trc_irq,
  output logic [15:0] trc_seq,
  output logic [1:0]  ovf
);

  // FIFO entry layout: {irq, pc, ir, seq}
  localparam int EW = 49;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  logic [1:0]    decode;
  logic [1:0]    irq_in;
  logic [15:0]   pc_in [2];
  logic [15:0]   ir_in [2];
  logic [EW-1:0] rd_data [2];
  logic [1:0]    fifo_empty;
  logic [1:0]    fifo_full;
  logic [1:0]    push_ok;
  logic [1:0]    drop;
  logic [1:0]    pop;

  assign decode   = {c1_decode, c0_decode};
  assign irq_in   = {c1_irq, c0_irq};
  assign pc_in[0] = c0_pc;
  assign pc_in[1] = c1_pc;
  assign ir_in[0] = c0_ir;
  assign ir_in[1] = c1_ir;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_core
      logic [15:0]   seq_reg;
      logic [AW:0]   wr_ptr_reg;
      logic [AW:0]   rd_ptr_reg;
      logic [EW-1:0] mem_reg [DEPTH];
      logic          push_req;

      assign push_req       = decode[gi] & trc_en;
      assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
      assign fifo_full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                              (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      assign push_ok[gi]    = push_req & (~fifo_full[gi] | pop[gi]);
      assign drop[gi]       = push_req & fifo_full[gi] & ~pop[gi];
      assign rd_data[gi]    = mem_reg[rd_ptr_reg[AW-1:0]];

      always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
          seq_reg    <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (decode[gi]) seq_reg <= seq_reg + 16'd1;
          if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      always_ff @(posedge mclk) begin
        if (push_ok[gi]) mem_reg[wr_ptr_reg[AW-1:0]] <= {irq_in[gi], pc_in[gi], ir_in[gi], seq_reg};
      end
    end
  endgenerate

  state_t      state_reg, state_next;
  logic        last_reg, last_next;
  logic        load;
  logic        grant;
  logic [1:0]  ovf_reg, ovf_next;
  logic        core_reg;
  logic [15:0] pc_reg, ir_reg, seq_reg;
  logic        irq_reg;

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    pop        = 2'b00;
    load       = (state_reg == ST_EMPTY) | ((state_reg == ST_HOLD) & trc_ready);
    // Both pending: serve the core that was not granted last.
    if (!fifo_empty[0] && !fifo_empty[1]) grant = ~last_reg;
    else                                  grant = ~fifo_empty[1];
    if (load) begin
      if (fifo_empty != 2'b11) begin
        pop        = grant ? 2'b10 : 2'b01;
        state_next = ST_HOLD;
        last_next  = grant;
      end else begin
        state_next = ST_EMPTY;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ovf_next[i] = ovf_reg[i];
      if (ovf_clr) ovf_next[i] = 1'b0;
      if (drop[i]) ovf_next[i] = 1'b1;
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_reg <= ST_EMPTY;
      last_reg  <= 1'b1;
      ovf_reg   <= 2'b00;
      core_reg  <= 1'b0;
      pc_reg    <= '0;
      ir_reg    <= '0;
      irq_reg   <= 1'b0;
      seq_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      ovf_reg   <= ovf_next;
      if (pop != 2'b00) begin
        core_reg                           <= grant;
        {irq_reg, pc_reg, ir_reg, seq_reg} <= rd_data[grant];
      end
    end
  end

  assign trc_valid = (state_reg == ST_HOLD);
  assign trc_core  = core_reg;
  assign trc_pc    = pc_reg;
  assign trc_ir    = ir_reg;
  assign trc_irq   = irq_reg;
  assign trc_seq   = seq_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pu_msp430_trace_arbiter.sv
// Bench for pu_msp430_trace_arbiter: per-core expected-entry queues filled as decodes are
// driven, compared as the trace port hands entries over.
module tb_pu_msp430_trace_arbiter;

  logic        mclk = 1'b0;
  logic        puc_rst, trc_en, ovf_clr;
  logic        c0_decode, c0_irq, c1_decode, c1_irq;
  logic [15:0] c0_pc, c0_ir, c1_pc, c1_ir;
  logic        trc_valid, trc_ready, trc_core, trc_irq;
  logic [15:0] trc_pc, trc_ir, trc_seq;
  logic [1:0]  ovf;

  pu_msp430_trace_arbiter #(.DEPTH(4), .AW(2)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .trc_en(trc_en), .ovf_clr(ovf_clr),
    .c0_decode(c0_decode), .c0_pc(c0_pc), .c0_ir(c0_ir), .c0_irq(c0_irq),
    .c1_decode(c1_decode), .c1_pc(c1_pc), .c1_ir(c1_ir), .c1_irq(c1_irq),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_core(trc_core),
    .trc_pc(trc_pc), .trc_ir(trc_ir), .trc_irq(trc_irq), .trc_seq(trc_seq), .ovf(ovf)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic        d0, d1, en;
    logic [15:0] pc0, ir0, pc1, ir1;
    logic        irq0, irq1;
    logic        acc0, acc1;
    logic [1:0]  exp_ovf;
  } vec_t;

  typedef struct packed {
    logic        core;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        irq;
    logic [15:0] seq;
  } ent_t;

  ent_t        exp_q0[$];
  ent_t        exp_q1[$];
  vec_t        tbl[13];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [15:0] seq_m0, seq_m1;
  bit          fair_mode = 1'b0;
  bit          have_prev = 1'b0;
  logic        prev_core, exp_core;
  ent_t        mon_got, mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Handshake happens at the next posedge; sample it half a cycle earlier.
  always @(negedge mclk) begin
    if (!puc_rst && trc_valid && trc_ready) begin
      mon_got = {trc_core, trc_pc, trc_ir, trc_irq, trc_seq};
      $display("trace core=%0d pc=%h ir=%h irq=%0d seq=%0d", trc_core, trc_pc, trc_ir, trc_irq, trc_seq);
      if (trc_core == 1'b0) begin
        check("c0_entry_expected", exp_q0.size() != 0, 1);
        if (exp_q0.size() != 0) begin
          mon_exp = exp_q0.pop_front();
          check("c0_entry", mon_got, mon_exp);
        end
      end else begin
        check("c1_entry_expected", exp_q1.size() != 0, 1);
        if (exp_q1.size() != 0) begin
          mon_exp = exp_q1.pop_front();
          check("c1_entry", mon_got, mon_exp);
        end
      end
      if (fair_mode) begin
        if (have_prev) begin
          exp_core = ~prev_core;
          check("rr_alternate", trc_core, exp_core);
        end
        prev_core = trc_core;
        have_prev = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    trc_en    = v.en;
    c0_decode = v.d0; c0_pc = v.pc0; c0_ir = v.ir0; c0_irq = v.irq0;
    c1_decode = v.d1; c1_pc = v.pc1; c1_ir = v.ir1; c1_irq = v.irq1;
    if (v.d0 && v.acc0) exp_q0.push_back({1'b0, v.pc0, v.ir0, v.irq0, seq_m0});
    if (v.d1 && v.acc1) exp_q1.push_back({1'b1, v.pc1, v.ir1, v.irq1, seq_m1});
    if (v.d0) seq_m0++;
    if (v.d1) seq_m1++;
    step();
    c0_decode = 1'b0;
    c1_decode = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  function automatic vec_t c0_vec(input logic [15:0] pc, input logic [15:0] ir, input logic acc);
    vec_t v;
    v.d0 = 1'b1; v.d1 = 1'b0; v.en = 1'b1;
    v.pc0 = pc; v.ir0 = ir; v.irq0 = pc[0];
    v.pc1 = '0; v.ir1 = '0; v.irq1 = 1'b0;
    v.acc0 = acc; v.acc1 = 1'b0; v.exp_ovf = 2'b00;
    return v;
  endfunction

  task automatic drain(input int max_cyc, input string name);
    int n = 0;
    trc_ready = 1'b1;
    while ((exp_q0.size() + exp_q1.size()) != 0 && n < max_cyc) begin
      step();
      n++;
    end
    step();
    step();
    check(name, exp_q0.size() + exp_q1.size(), 0);
    check({name, "_idle"}, trc_valid, 0);
  endtask

  task automatic apply_reset();
    puc_rst   = 1'b1;
    trc_ready = 1'b0;
    c0_decode = 1'b0;
    c1_decode = 1'b0;
    ovf_clr   = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    seq_m0 = '0;
    seq_m1 = '0;
    step();
    step();
    puc_rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] s;
    puc_rst = 1'b1; trc_en = 1'b0; ovf_clr = 1'b0; trc_ready = 1'b0;
    c0_decode = 1'b0; c0_pc = '0; c0_ir = '0; c0_irq = 1'b0;
    c1_decode = 1'b0; c1_pc = '0; c1_ir = '0; c1_irq = 1'b0;
    seq_m0 = '0; seq_m1 = '0;

    // Rows 0-4: core 1 with capture disabled then enabled; rows 5-12: both cores every cycle.
    for (int i = 0; i < 13; i++) begin
      tbl[i].d0 = (i >= 5); tbl[i].d1 = 1'b1;
      tbl[i].en = (i >= 3);
      tbl[i].pc0 = 16'hA000 + 16'(i); tbl[i].ir0 = 16'h4000 + 16'(i); tbl[i].irq0 = (i == 8);
      tbl[i].pc1 = 16'hB000 + 16'(i); tbl[i].ir1 = 16'h5000 + 16'(i); tbl[i].irq1 = (i == 9);
      tbl[i].acc0 = 1'b1;
      tbl[i].acc1 = (i >= 3) && (i != 12);
      tbl[i].exp_ovf = (i == 12) ? 2'b10 : 2'b00;
    end

    repeat (3) step();
    check("rst_valid", trc_valid, 0);
    check("rst_outputs", {trc_core, trc_pc, trc_ir, trc_irq, trc_seq}, 0);
    check("rst_ovf", ovf, 0);
    puc_rst = 1'b0;
    step();

    // Single event from core 0
    trc_ready = 1'b1;
    apply(c0_vec(16'hF800, 16'h4303, 1'b1));
    check("t1_no_bypass", trc_valid, 0);
    step();
    check("t1_valid", trc_valid, 1);
    check("t1_core", trc_core, 0);
    check("t1_pc", trc_pc, 16'hF800);
    check("t1_ir", trc_ir, 16'h4303);
    check("t1_seq", trc_seq, 0);
    drain(10, "t1_drain");

    // Backpressure: 1 in output + 4 in FIFO, sixth event dropped
    trc_ready = 1'b0;
    s = seq_m0;
    for (int i = 0; i < 6; i++) apply(c0_vec(16'h0100 + 16'(i), 16'h4100 + 16'(i), i < 5));
    check("t2_ovf_set", ovf, 2'b01);
    check("t2_hold_valid", trc_valid, 1);
    check("t2_hold_seq", trc_seq, s);
    drain(20, "t2_drain");
    check("t2_ovf_sticky", ovf, 2'b01);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t2_ovf_clr", ovf, 2'b00);

    // Full FIFO with pop and push in the same cycle, then drops with/without ovf_clr
    trc_ready = 1'b0;
    for (int i = 0; i < 5; i++) apply(c0_vec(16'h0200 + 16'(i), 16'h4200 + 16'(i), 1'b1));
    trc_ready = 1'b1;
    apply(c0_vec(16'h0205, 16'h4205, 1'b1));
    trc_ready = 1'b0;
    check("t5_full_pop_push_ovf", ovf, 2'b00);
    apply(c0_vec(16'h0206, 16'h4206, 1'b0));
    check("t5_drop_ovf", ovf, 2'b01);
    ovf_clr = 1'b1;
    apply(c0_vec(16'h0207, 16'h4207, 1'b0));
    check("t5_clr_vs_drop", ovf, 2'b01);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t5_ovf_clr", ovf, 2'b00);
    drain(20, "t5_drain");

    // Capture enable gating on core 1 (fresh reset so seq starts at 0)
    apply_reset();
    trc_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(tbl[i]);
      check($sformatf("vec%0d_ovf", i), ovf, tbl[i].exp_ovf);
    end
    drain(10, "t4_drain");

    // Both cores decoding every cycle
    fair_mode = 1'b1;
    have_prev = 1'b0;
    for (int i = 5; i < 13; i++) begin
      apply(tbl[i]);
      check($sformatf("vec%0d_ovf", i), ovf, tbl[i].exp_ovf);
    end
    drain(40, "t3_drain");
    fair_mode = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", ovf, 2'b00);

    // Asynchronous reset with an entry held and FIFOs partly full
    trc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tbl[0].d0 = 1'b1; tbl[0].d1 = 1'b1; tbl[0].en = 1'b1;
      tbl[0].acc0 = 1'b1; tbl[0].acc1 = 1'b1;
      apply(tbl[0]);
    end
    check("t6_pre_valid", trc_valid, 1);
    #1;
    puc_rst = 1'b1;
    #1;
    check("t6_async_valid", trc_valid, 0);
    check("t6_async_seq", trc_seq, 0);
    exp_q0.delete();
    exp_q1.delete();
    seq_m0 = '0;
    seq_m1 = '0;
    step();
    puc_rst = 1'b0;
    step();
    check("t6_after_rst_valid", trc_valid, 0);
    trc_ready = 1'b1;
    apply(c0_vec(16'hF810, 16'h1300, 1'b1));
    step();
    check("t6_restart_valid", trc_valid, 1);
    check("t6_restart_seq", trc_seq, 0);
    drain(10, "t6_drain");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
